// File: rtl/branch_resolve_queue_if.sv
// Signal bundle between fetch/predictor, the execute branch unit, ROB retire and the
// branch resolve queue. The master side drives requests and the slave side is the queue.
interface branch_resolve_queue_if #(
   parameter int BRQ_SZ = 8,
   parameter int ADDR_W = 32,
   parameter int HIST_W = 4
);
   localparam int IDX_W = $clog2(BRQ_SZ);

   logic              alloc_valid;
   logic [ADDR_W-1:0] alloc_pc;
   logic              alloc_pred_taken;
   logic [ADDR_W-1:0] alloc_pred_target;
   logic [HIST_W-1:0] alloc_hist;
   logic              alloc_ready;
   logic [IDX_W-1:0]  alloc_idx;
   logic              resolve_valid;
   logic [IDX_W-1:0]  resolve_idx;
   logic              resolve_taken;
   logic [ADDR_W-1:0] resolve_target;
   logic [ADDR_W-1:0] resolve_fallthru;
   logic              mispredict;
   logic [ADDR_W-1:0] mispredict_pc;
   logic [IDX_W-1:0]  mispredict_idx;
   logic              retire_valid;
   logic              upd_valid;
   logic [ADDR_W-1:0] upd_pc;
   logic              upd_taken;
   logic [HIST_W-1:0] upd_hist;
   logic [IDX_W:0]    count;

   modport master (
      output alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target, alloc_hist,
             resolve_valid, resolve_idx, resolve_taken, resolve_target, resolve_fallthru,
             retire_valid,
      input  alloc_ready, alloc_idx, mispredict, mispredict_pc, mispredict_idx,
             upd_valid, upd_pc, upd_taken, upd_hist, count
   );

   modport slave (
      input  alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target, alloc_hist,
             resolve_valid, resolve_idx, resolve_taken, resolve_target, resolve_fallthru,
             retire_valid,
      output alloc_ready, alloc_idx, mispredict, mispredict_pc, mispredict_idx,
             upd_valid, upd_pc, upd_taken, upd_hist, count
   );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-flight branch tracker: allocates at fetch, checks predictions at execute (redirect +
// squash of younger entries), and emits predictor training updates at in-order retirement.
module branch_resolve_queue #(
   parameter int BRQ_SZ = 8,
   parameter int ADDR_W = 32,
   parameter int HIST_W = 4
) (
   input logic                   i_clock,
   input logic                   i_reset,
   branch_resolve_queue_if.slave bus
);
   localparam int IDX_W = $clog2(BRQ_SZ);
   localparam int PTR_W = IDX_W + 1;

   logic [PTR_W-1:0]              r_head, r_tail;
   logic [BRQ_SZ-1:0]             r_valid, r_resolved, r_pred_taken, r_act_taken;
   logic [BRQ_SZ-1:0][ADDR_W-1:0] r_pc, r_pred_tgt;
   logic [BRQ_SZ-1:0][HIST_W-1:0] r_hist;
   logic                          r_mis, r_upd_valid, r_upd_taken;
   logic [ADDR_W-1:0]             r_mis_pc, r_upd_pc;
   logic [IDX_W-1:0]              r_mis_idx;
   logic [HIST_W-1:0]             r_upd_hist;

   logic [IDX_W-1:0]  w_head_idx, w_tail_idx, w_res_idx, w_res_off;
   logic [PTR_W-1:0]  w_count, w_sq_tail;
   logic              w_full, w_res_ok, w_mis, w_alloc, w_ret_ok;
   logic [BRQ_SZ-1:0] w_young;

   assign w_head_idx = r_head[IDX_W-1:0];
   assign w_tail_idx = r_tail[IDX_W-1:0];
   assign w_res_idx  = bus.resolve_idx;
   assign w_count    = r_tail - r_head;
   assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);

   assign w_res_ok = bus.resolve_valid && r_valid[w_res_idx] && !r_resolved[w_res_idx];
   assign w_mis    = w_res_ok && ((bus.resolve_taken != r_pred_taken[w_res_idx]) ||
                     (bus.resolve_taken && (bus.resolve_target != r_pred_tgt[w_res_idx])));
   // Wrong-path allocs arriving with a mispredict are dropped
   assign w_alloc  = bus.alloc_valid && !w_full && !w_mis;
   assign w_ret_ok = bus.retire_valid && r_valid[w_head_idx] && r_resolved[w_head_idx];

   // Distance from head gives age; the new tail keeps the correct wrap bit relative to head
   assign w_res_off = w_res_idx - w_head_idx;
   assign w_sq_tail = r_head + PTR_W'(w_res_off) + PTR_W'(1);

   always_comb begin
      w_young = '0;
      for (int i = 0; i < BRQ_SZ; i++)
         w_young[i] = w_mis && (IDX_W'(IDX_W'(i) - w_head_idx) > w_res_off);
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_head      <= '0;
         r_tail      <= '0;
         r_valid     <= '0;
         r_resolved  <= '0;
         r_mis       <= 1'b0;
         r_mis_pc    <= '0;
         r_mis_idx   <= '0;
         r_upd_valid <= 1'b0;
         r_upd_pc    <= '0;
         r_upd_taken <= 1'b0;
         r_upd_hist  <= '0;
      end else begin
         if (w_ret_ok) r_head <= r_head + PTR_W'(1);
         if (w_mis)        r_tail <= w_sq_tail;
         else if (w_alloc) r_tail <= r_tail + PTR_W'(1);
         for (int i = 0; i < BRQ_SZ; i++) begin
            if (w_res_ok && (w_res_idx == IDX_W'(i))) r_resolved[i] <= 1'b1;
            if (w_alloc && (w_tail_idx == IDX_W'(i))) begin
               r_valid[i]    <= 1'b1;
               r_resolved[i] <= 1'b0;
            end else if (w_young[i] || (w_ret_ok && (w_head_idx == IDX_W'(i)))) begin
               r_valid[i] <= 1'b0;
            end
         end
         r_mis <= w_mis;
         if (w_mis) begin
            r_mis_idx <= w_res_idx;
            r_mis_pc  <= bus.resolve_taken ? bus.resolve_target : bus.resolve_fallthru;
         end
         r_upd_valid <= w_ret_ok;
         if (w_ret_ok) begin
            r_upd_pc    <= r_pc[w_head_idx];
            r_upd_taken <= r_act_taken[w_head_idx];
            r_upd_hist  <= r_hist[w_head_idx];
         end
      end
   end

   // Payload storage needs no reset: valid bits gate every use
   always_ff @(posedge i_clock) begin
      if (w_alloc) begin
         r_pc[w_tail_idx]         <= bus.alloc_pc;
         r_pred_taken[w_tail_idx] <= bus.alloc_pred_taken;
         r_pred_tgt[w_tail_idx]   <= bus.alloc_pred_target;
         r_hist[w_tail_idx]       <= bus.alloc_hist;
      end
      if (w_res_ok) r_act_taken[w_res_idx] <= bus.resolve_taken;
   end

   assign bus.alloc_ready    = !w_full;
   assign bus.alloc_idx      = w_tail_idx;
   assign bus.count          = w_count;
   assign bus.mispredict     = r_mis;
   assign bus.mispredict_pc  = r_mis_pc;
   assign bus.mispredict_idx = r_mis_idx;
   assign bus.upd_valid      = r_upd_valid;
   assign bus.upd_pc         = r_upd_pc;
   assign bus.upd_taken      = r_upd_taken;
   assign bus.upd_hist       = r_upd_hist;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios plus randomized traffic, all checked
// against an ordered-list model of in-flight branches.
module tb_branch_resolve_queue;
   localparam int N  = 8;
   localparam int AW = 32;
   localparam int HW = 4;
   localparam int IW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   branch_resolve_queue_if #(.BRQ_SZ(N), .ADDR_W(AW), .HIST_W(HW)) bus ();
   branch_resolve_queue #(.BRQ_SZ(N), .ADDR_W(AW), .HIST_W(HW)) dut (
      .i_clock(clk), .i_reset(rst), .bus(bus));

   typedef struct {
      logic [IW-1:0] idx;
      logic [AW-1:0] pc;
      logic          pt;
      logic [AW-1:0] tgt;
      logic [HW-1:0] hist;
      logic          res;
      logic          act;
   } ent_t;

   ent_t          mq[$];   // in-flight branches, oldest first
   int            m_tail;  // slot the next alloc will take
   logic          e_mis, e_upd, e_upd_taken;
   logic [AW-1:0] e_mis_pc, e_upd_pc;
   logic [IW-1:0] e_mis_idx;
   logic [HW-1:0] e_upd_hist;
   int            checks = 0;
   int            failures = 0;

   task automatic idle();
      bus.alloc_valid = 0; bus.alloc_pc = '0; bus.alloc_pred_taken = 0;
      bus.alloc_pred_target = '0; bus.alloc_hist = '0;
      bus.resolve_valid = 0; bus.resolve_idx = '0; bus.resolve_taken = 0;
      bus.resolve_target = '0; bus.resolve_fallthru = '0; bus.retire_valid = 0;
   endtask

   // Advance the model by the inputs currently driven, then clock the DUT
   task automatic tick();
      bit   ready, can_ret, mis;
      int   p;
      ent_t e;
      if (rst) begin
         mq.delete(); m_tail = 0;
         e_mis = 0; e_mis_pc = '0; e_mis_idx = '0;
         e_upd = 0; e_upd_pc = '0; e_upd_taken = 0; e_upd_hist = '0;
      end else begin
         ready   = mq.size() < N;
         can_ret = bus.retire_valid && (mq.size() > 0) && mq[0].res;
         mis = 0; p = -1;
         if (bus.resolve_valid)
            for (int k = 0; k < mq.size(); k++)
               if (mq[k].idx == bus.resolve_idx && !mq[k].res) p = k;
         if (p >= 0) begin
            mis = (bus.resolve_taken != mq[p].pt) ||
                  (bus.resolve_taken && bus.resolve_target != mq[p].tgt);
            mq[p].res = 1'b1;
            mq[p].act = bus.resolve_taken;
         end
         e_mis = mis;
         if (mis) begin
            e_mis_idx = bus.resolve_idx;
            e_mis_pc  = bus.resolve_taken ? bus.resolve_target : bus.resolve_fallthru;
            while (mq.size() > p + 1) void'(mq.pop_back());
            m_tail = (int'(bus.resolve_idx) + 1) % N;
         end else if (bus.alloc_valid && ready) begin
            e.idx = IW'(m_tail); e.pc = bus.alloc_pc; e.pt = bus.alloc_pred_taken;
            e.tgt = bus.alloc_pred_target; e.hist = bus.alloc_hist; e.res = 0; e.act = 0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % N;
         end
         e_upd = can_ret;
         if (can_ret) begin
            e_upd_pc = mq[0].pc; e_upd_taken = mq[0].act; e_upd_hist = mq[0].hist;
            void'(mq.pop_front());
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      idle(); rst = 1; tick(); rst = 0;
   endtask

   task automatic alloc1(input logic [AW-1:0] pc, input logic pt, input logic [AW-1:0] tgt,
                         input logic [HW-1:0] h);
      idle();
      bus.alloc_valid = 1; bus.alloc_pc = pc; bus.alloc_pred_taken = pt;
      bus.alloc_pred_target = tgt; bus.alloc_hist = h;
   endtask

   task automatic resolve1(input logic [IW-1:0] idx, input logic tk, input logic [AW-1:0] tgt,
                           input logic [AW-1:0] ft);
      bus.resolve_valid = 1; bus.resolve_idx = idx; bus.resolve_taken = tk;
      bus.resolve_target = tgt; bus.resolve_fallthru = ft;
   endtask

   task automatic test_reset();
      idle(); rst = 1; tick(); tick(); rst = 0;
      checks++; if (bus.count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
      checks++; if (bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.alloc_ready); end
      checks++; if (bus.alloc_idx !== 3'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", bus.alloc_idx); end
      checks++; if ({bus.mispredict, bus.mispredict_pc, bus.mispredict_idx} !== '0) begin failures++; $display("FAIL reset_mis got=%b/%h/%0d exp=0", bus.mispredict, bus.mispredict_pc, bus.mispredict_idx); end
      checks++; if ({bus.upd_valid, bus.upd_pc, bus.upd_taken, bus.upd_hist} !== '0) begin failures++; $display("FAIL reset_upd got=%b/%h/%b/%h exp=0", bus.upd_valid, bus.upd_pc, bus.upd_taken, bus.upd_hist); end
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < N; i++) begin
         alloc1(AW'(32'h1000 + i * 4), 0, '0, HW'(i));
         checks++; if (bus.alloc_idx !== IW'(i)) begin failures++; $display("FAIL fill_idx got=%0d exp=%0d", bus.alloc_idx, i); end
         tick();
      end
      checks++; if (bus.count !== 4'd8) begin failures++; $display("FAIL fill_count got=%0d exp=8", bus.count); end
      checks++; if (bus.alloc_ready !== 1'b0) begin failures++; $display("FAIL fill_ready got=%b exp=0", bus.alloc_ready); end
      alloc1(32'h2000, 0, '0, '0); tick();
      checks++; if (bus.count !== 4'd8) begin failures++; $display("FAIL fill_drop got=%0d exp=8", bus.count); end
      idle();
   endtask

   task automatic test_retire_update();
      do_reset();
      alloc1(32'h100, 1, 32'h200, 4'hA); tick();
      idle(); resolve1(0, 1, 32'h200, 32'h104); tick();
      checks++; if (bus.mispredict !== 1'b0) begin failures++; $display("FAIL ok_no_mis got=%b exp=0", bus.mispredict); end
      idle(); bus.retire_valid = 1; tick(); idle();
      checks++; if ({bus.upd_valid, bus.upd_pc, bus.upd_taken, bus.upd_hist} !== {1'b1, 32'h100, 1'b1, 4'hA})
         begin failures++; $display("FAIL upd_pulse got=%b/%h/%b/%h exp=1/100/1/a", bus.upd_valid, bus.upd_pc, bus.upd_taken, bus.upd_hist); end
      tick();
      checks++; if (bus.upd_valid !== 1'b0 || bus.count !== 4'd0) begin failures++; $display("FAIL upd_end got=%b/%0d exp=0/0", bus.upd_valid, bus.count); end
   endtask

   task automatic test_mispredict(input bit with_alloc);
      do_reset();
      for (int i = 0; i < 4; i++) begin alloc1(AW'(32'h140 + i * 16), 1, 32'h300, '0); tick(); end
      idle(); resolve1(1, 0, 32'h300, 32'h144);
      if (with_alloc) begin bus.alloc_valid = 1; bus.alloc_pc = 32'h999; end
      tick(); idle();
      checks++; if ({bus.mispredict, bus.mispredict_pc, bus.mispredict_idx} !== {1'b1, 32'h144, 3'd1})
         begin failures++; $display("FAIL mis_out got=%b/%h/%0d exp=1/144/1", bus.mispredict, bus.mispredict_pc, bus.mispredict_idx); end
      checks++; if (bus.count !== 4'd2) begin failures++; $display("FAIL mis_count got=%0d exp=2", bus.count); end
      if (with_alloc) begin
         checks++; if (bus.alloc_idx !== 3'd2) begin failures++; $display("FAIL squash_alloc_idx got=%0d exp=2", bus.alloc_idx); end
         alloc1(32'h500, 0, '0, '0); tick(); idle();
         checks++; if (bus.count !== 4'd3 || bus.mispredict !== 1'b0) begin failures++; $display("FAIL squash_realloc got=%0d/%b exp=3/0", bus.count, bus.mispredict); end
      end else begin
         resolve1(2, 0, '0, 32'h777); tick(); idle();
         checks++; if (bus.mispredict !== 1'b0 || bus.count !== 4'd2) begin failures++; $display("FAIL squashed_resolve got=%b/%0d exp=0/2", bus.mispredict, bus.count); end
      end
   endtask

   task automatic test_retire_unresolved();
      do_reset();
      alloc1(32'h40, 0, '0, 4'h3); tick();
      alloc1(32'h44, 1, 32'h80, 4'h5); tick();
      idle(); bus.retire_valid = 1; tick(); idle();
      checks++; if (bus.upd_valid !== 1'b0 || bus.count !== 4'd2) begin failures++; $display("FAIL ret_unres got=%b/%0d exp=0/2", bus.upd_valid, bus.count); end
      resolve1(1, 1, 32'h80, 32'h48); tick(); idle();
      resolve1(1, 0, 32'h80, 32'h48); tick(); idle();
      checks++; if (bus.mispredict !== 1'b0) begin failures++; $display("FAIL re_resolve got=%b exp=0", bus.mispredict); end
      resolve1(0, 0, '0, 32'h44); bus.retire_valid = 1; tick(); idle();
      checks++; if (bus.upd_valid !== 1'b0 || bus.mispredict !== 1'b0) begin failures++; $display("FAIL ret_same_cycle got=%b/%b exp=0/0", bus.upd_valid, bus.mispredict); end
      bus.retire_valid = 1; tick(); idle();
      checks++; if ({bus.upd_valid, bus.upd_pc, bus.upd_taken, bus.upd_hist} !== {1'b1, 32'h40, 1'b0, 4'h3})
         begin failures++; $display("FAIL ret_head got=%b/%h/%b/%h exp=1/40/0/3", bus.upd_valid, bus.upd_pc, bus.upd_taken, bus.upd_hist); end
      checks++; if (bus.count !== 4'd1) begin failures++; $display("FAIL ret_count got=%0d exp=1", bus.count); end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         alloc1(AW'(32'h2000 + i * 4), i[0], 32'h3000, HW'(i));
         checks++; if (bus.alloc_idx !== IW'(i % N)) begin failures++; $display("FAIL wrap_idx i=%0d got=%0d exp=%0d", i, bus.alloc_idx, i % N); end
         tick(); idle();
         resolve1(IW'(i % N), i[0], 32'h3000, AW'(32'h2004 + i * 4)); tick(); idle();
         bus.retire_valid = 1; tick(); idle();
         checks++; if (bus.mispredict !== 1'b0 || bus.upd_valid !== 1'b1 || bus.upd_pc !== AW'(32'h2000 + i * 4) || bus.count !== 4'd0)
            begin failures++; $display("FAIL wrap_trip i=%0d got=%b/%b/%h/%0d exp=0/1/%h/0", i, bus.mispredict, bus.upd_valid, bus.upd_pc, bus.count, 32'h2000 + i * 4); end
      end
      for (int i = 0; i < N; i++) begin alloc1(AW'(i), 0, '0, '0); tick(); end
      idle();
      checks++; if (bus.count !== 4'd8 || bus.alloc_ready !== 1'b0 || bus.alloc_idx !== 3'd4)
         begin failures++; $display("FAIL wrap_full got=%0d/%b/%0d exp=8/0/4", bus.count, bus.alloc_ready, bus.alloc_idx); end
   endtask

   task automatic test_random();
      int k;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         idle();
         rst = (c == 400);
         bus.alloc_valid = ($urandom_range(0, 99) < 60);
         bus.alloc_pc = AW'($urandom_range(0, 1023)) << 2;
         bus.alloc_pred_taken = $urandom_range(0, 1);
         bus.alloc_pred_target = AW'($urandom_range(0, 3)) << 4;
         bus.alloc_hist = HW'($urandom_range(0, 15));
         bus.resolve_valid = ($urandom_range(0, 99) < 55);
         bus.resolve_fallthru = AW'($urandom_range(0, 1023)) << 2;
         if (mq.size() > 0 && $urandom_range(0, 9) < 8) begin
            k = $urandom_range(0, mq.size() - 1);
            bus.resolve_idx = mq[k].idx;
            bus.resolve_taken = ($urandom_range(0, 9) < 8) ? mq[k].pt : !mq[k].pt;
            bus.resolve_target = ($urandom_range(0, 9) < 8) ? mq[k].tgt : AW'($urandom_range(0, 3)) << 4;
         end else begin
            bus.resolve_idx = IW'($urandom_range(0, N - 1));
            bus.resolve_taken = $urandom_range(0, 1);
            bus.resolve_target = AW'($urandom_range(0, 3)) << 4;
         end
         bus.retire_valid = ($urandom_range(0, 99) < 50);
         tick();
         rst = 0;
         checks++; if (bus.count !== 4'(mq.size())) begin failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, bus.count, mq.size()); end
         checks++; if (bus.alloc_ready !== (mq.size() < N)) begin failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, bus.alloc_ready, mq.size() < N); end
         checks++; if (bus.alloc_idx !== IW'(m_tail)) begin failures++; $display("FAIL rnd_idx c=%0d got=%0d exp=%0d", c, bus.alloc_idx, m_tail); end
         checks++; if (bus.mispredict !== e_mis) begin failures++; $display("FAIL rnd_mis c=%0d got=%b exp=%b", c, bus.mispredict, e_mis); end
         if (e_mis) begin
            checks++; if (bus.mispredict_pc !== e_mis_pc || bus.mispredict_idx !== e_mis_idx)
               begin failures++; $display("FAIL rnd_mis_data c=%0d got=%h/%0d exp=%h/%0d", c, bus.mispredict_pc, bus.mispredict_idx, e_mis_pc, e_mis_idx); end
         end
         checks++; if (bus.upd_valid !== e_upd) begin failures++; $display("FAIL rnd_upd c=%0d got=%b exp=%b", c, bus.upd_valid, e_upd); end
         if (e_upd) begin
            checks++; if (bus.upd_pc !== e_upd_pc || bus.upd_taken !== e_upd_taken || bus.upd_hist !== e_upd_hist)
               begin failures++; $display("FAIL rnd_upd_data c=%0d got=%h/%b/%h exp=%h/%b/%h", c, bus.upd_pc, bus.upd_taken, bus.upd_hist, e_upd_pc, e_upd_taken, e_upd_hist); end
         end
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_fill();
      test_retire_update();
      test_mispredict(0);
      test_mispredict(1);
      test_retire_unresolved();
      test_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Tracks every in-flight predicted branch from fetch until retirement.
- At execute completion, compares each branch's actual outcome against its prediction. Raises a registered mispredict redirect and squashes younger entries.
- At in-order retirement, emits the training update (PC, actual direction, history snapshot) that drives the PAg branch predictor's BHT/PHT.
- Sits between fetch/predictor, the execute branch unit and the ROB retire port.

Parameters:
- BRQ_SZ, 8, number of queue entries; must be a power of 2, ≥2.
- ADDR_W, 32, PC/target width.
- HIST_W, 4, width of the local-history snapshot carried per branch.
- IDX_W, $clog2(BRQ_SZ), entry index width (derived).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- alloc_valid  in  1  fetch pushes a predicted branch
- alloc_pc  in  ADDR_W  branch PC
- alloc_pred_taken  in  1  predicted direction
- alloc_pred_target  in  ADDR_W  predicted target (meaningful if taken)
- alloc_hist  in  HIST_W  predictor history used for this prediction
- alloc_ready  out  1  queue can accept an entry this cycle
- alloc_idx  out  IDX_W  index assigned to the current alloc (= tail)
- resolve_valid  in  1  execute reports a resolved branch
- resolve_idx  in  IDX_W  entry being resolved
- resolve_taken  in  1  actual direction
- resolve_target  in  ADDR_W  actual taken target
- resolve_fallthru  in  ADDR_W  PC+4 of the branch
- mispredict  out  1  one-cycle redirect pulse
- mispredict_pc  out  ADDR_W  correct fetch PC
- mispredict_idx  out  IDX_W  mispredicting entry
- retire_valid  in  1  ROB retires the oldest branch
- upd_valid  out  1  predictor training pulse
- upd_pc  out  ADDR_W  PC to train
- upd_taken  out  1  actual direction
- upd_hist  out  HIST_W  history snapshot to train
- count  out  IDX_W+1  occupied entries

Behaviour:
- Storage and pointers
  - Circular buffer with head/tail pointers of IDX_W+1 bits; the MSB is the wrap bit.
  - empty when head==tail; full when the index bits are equal and the wrap bits differ.
  - count = tail − head, modulo 2^(IDX_W+1).
  - Per-entry state: valid, resolved, pc, pred_taken, pred_target, hist, actual_taken.
- Reset
  - head=tail=0, all valid/resolved cleared, count=0.
  - Outputs: mispredict=0, mispredict_pc=0, mispredict_idx=0, upd_valid=0, upd_pc=0, upd_taken=0, upd_hist=0.
  - alloc_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all entries and any pending pulse.
- Allocate
  - alloc_ready = !full, computed from the current count; a same-cycle retire does not free space.
  - alloc_valid && alloc_ready writes the entry at tail, valid=1, resolved=0, tail++.
  - alloc_valid while full is dropped.
- Resolve
  - Accepted only if entry[resolve_idx].valid && !resolved; otherwise ignored with no outputs.
  - On acceptance, sets resolved=1 and actual_taken.
  - Mispredict iff (resolve_taken != pred_taken) || (resolve_taken && resolve_target != pred_target).
  - On mispredict, registered outputs are valid the next cycle (1-cycle latency): mispredict=1 for exactly one cycle, mispredict_idx=resolve_idx, and mispredict_pc = resolve_target if taken, else resolve_fallthru.
  - Squash on the same edge: tail <= resolve_idx+1 with the wrap bit recomputed relative to head; all entries younger than resolve_idx get valid=0.
  - An alloc in the same cycle as a mispredicting resolve is discarded, since it belongs to the wrong path.
- Retire
  - Accepted only if the head entry is valid && resolved; otherwise ignored.
  - On acceptance: head++, entry invalidated. Next cycle upd_valid=1 for one cycle with upd_pc/upd_taken/upd_hist from that entry.
  - Retire of the head and resolve of a different entry in the same cycle are both honoured.
- Simultaneous events
  - Alloc, resolve and retire may all fire in one cycle; count reflects the net change.
  - A mispredict squash overrides the tail increment.
- Wrap-around: pointers wrap modulo BRQ_SZ; correct full/empty detection across the wrap is required.

Test Plan:
- Reset, then alloc 8 entries with pred_taken=0 → alloc_idx 0..7, count=8, alloc_ready=0; a 9th alloc is dropped and count stays 8.
- Alloc idx0 (pc=0x100, pred_taken=1, target=0x200), resolve taken with target 0x200, retire → no mispredict; next cycle upd_valid=1, upd_pc=0x100, upd_taken=1.
- Alloc idx0..3, resolve idx1 not-taken (pred taken), fallthru=0x144 → next cycle mispredict=1, mispredict_pc=0x144, mispredict_idx=1; count=2, and a resolve to idx2 afterward is ignored.
- Same as the previous scenario with alloc_valid asserted in the resolve cycle → the alloc is discarded; the next alloc receives idx2.
- Retire while head is unresolved → ignored; resolve head, then retire → upd_valid pulse; resolving an already-resolved index → no effect.
- Run 20 alloc/resolve/retire triples with BRQ_SZ=8 to force two pointer wraps → full/empty and alloc_idx are correct across the wrap, with no spurious mispredict.
